// File: rtl/motor_link_responder.sv
// Board-side responder for the motor UART link: parses CRC-8 protected command
// frames, latches setpoint/mode, and answers valid commands with a status frame.
module motor_link_responder #(
   parameter logic [7:0]  BOARD_ID      = 8'h00,
   parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
   parameter int unsigned TIMEOUT_US    = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [23:0] encoder0_position,
   input  logic [23:0] encoder1_position,
   input  logic [23:0] displacement,
   output logic [23:0] setpoint,
   output logic [7:0]  control_mode,
   output logic        cmd_strobe,
   output logic [15:0] frame_error_count,
   output logic        tx_busy
);

   // Product is formed in 64 bits: the default parameters overflow 32 bits.
   localparam longint unsigned TO_WIDE =
      64'(TIMEOUT_US) * 64'(CLOCK_FREQ_HZ) / 64'd1_000_000;
   localparam int unsigned TIMEOUT_CYCLES = 32'(TO_WIDE);
   localparam int unsigned GAP_W          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_HDR  = 8'hAA;
   localparam logic [7:0] STAT_HDR = 8'h55;

   typedef enum logic [2:0] {
      RX_HUNT,
      RX_ID,
      RX_MODE,
      RX_SP2,
      RX_SP1,
      RX_SP0,
      RX_CRC
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_LOAD,
      TX_SEND
   } tx_state_t;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // ---------------------------------------------------------------- RX side
   rx_state_t        rx_state_q, rx_state_d;
   logic [7:0]       rx_crc_q, rx_crc_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]       id_q, id_d;
   logic [7:0]       mode_q, mode_d;
   logic [23:0]      sp_q, sp_d;
   logic [23:0]      setpoint_q, setpoint_d;
   logic [7:0]       ctrl_mode_q, ctrl_mode_d;
   logic             strobe_q, strobe_d;
   logic [15:0]      err_q, err_d;
   logic             err_inc;
   logic             resp_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q  <= RX_HUNT;
         rx_crc_q    <= '0;
         gap_q       <= '0;
         id_q        <= '0;
         mode_q      <= '0;
         sp_q        <= '0;
         setpoint_q  <= '0;
         ctrl_mode_q <= '0;
         strobe_q    <= 1'b0;
         err_q       <= '0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_crc_q    <= rx_crc_d;
         gap_q       <= gap_d;
         id_q        <= id_d;
         mode_q      <= mode_d;
         sp_q        <= sp_d;
         setpoint_q  <= setpoint_d;
         ctrl_mode_q <= ctrl_mode_d;
         strobe_q    <= strobe_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_crc_d    = rx_crc_q;
      gap_d       = gap_q;
      id_d        = id_q;
      mode_d      = mode_q;
      sp_d        = sp_q;
      setpoint_d  = setpoint_q;
      ctrl_mode_d = ctrl_mode_q;
      strobe_d    = 1'b0;
      err_inc     = 1'b0;
      resp_req    = 1'b0;

      if (rx_state_q == RX_HUNT) begin
         gap_d = '0;
         if (rx_valid && rx_data == CMD_HDR) begin
            rx_state_d = RX_ID;
            rx_crc_d   = '0;
         end
      end else if (rx_valid) begin
         // Every byte inside a frame is data, including 8'hAA.
         gap_d    = '0;
         rx_crc_d = crc8_step(rx_crc_q, rx_data);
         unique case (rx_state_q)
            RX_ID: begin
               id_d       = rx_data;
               rx_state_d = RX_MODE;
            end
            RX_MODE: begin
               mode_d     = rx_data;
               rx_state_d = RX_SP2;
            end
            RX_SP2: begin
               sp_d       = {sp_q[15:0], rx_data};
               rx_state_d = RX_SP1;
            end
            RX_SP1: begin
               sp_d       = {sp_q[15:0], rx_data};
               rx_state_d = RX_SP0;
            end
            RX_SP0: begin
               sp_d       = {sp_q[15:0], rx_data};
               rx_state_d = RX_CRC;
            end
            RX_CRC: begin
               rx_state_d = RX_HUNT;
               if (rx_data != rx_crc_q) begin
                  err_inc = 1'b1;
               end else if (id_q == BOARD_ID) begin
                  setpoint_d  = sp_q;
                  ctrl_mode_d = mode_q;
                  strobe_d    = 1'b1;
                  resp_req    = 1'b1;
               end
            end
            default: rx_state_d = RX_HUNT;
         endcase
      end else if (gap_q == GAP_LAST) begin
         rx_state_d = RX_HUNT;
         gap_d      = '0;
         err_inc    = 1'b1;
      end else begin
         gap_d = gap_q + 1'b1;
      end

      err_d = err_q;
      if (err_inc && err_q != '1) begin
         err_d = err_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------- TX side
   tx_state_t   tx_state_q, tx_state_d;
   logic [71:0] buf_q, buf_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  tx_crc_q, tx_crc_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        tx_busy_q, tx_busy_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         buf_q      <= '0;
         idx_q      <= '0;
         tx_crc_q   <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         tx_crc_q   <= tx_crc_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_busy_q  <= tx_busy_d;
      end
   end

   // TX_LOAD separates the snapshot edge (with cmd_strobe) from the edge that
   // raises tx_valid; it counts as "not idle" so a new request is dropped.
   always_comb begin
      tx_state_d = tx_state_q;
      buf_d      = buf_q;
      idx_d      = idx_q;
      tx_crc_d   = tx_crc_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      tx_busy_d  = tx_busy_q;

      unique case (tx_state_q)
         TX_IDLE: begin
            if (resp_req) begin
               buf_d      = {encoder0_position, encoder1_position, displacement};
               tx_state_d = TX_LOAD;
            end
         end
         TX_LOAD: begin
            tx_state_d = TX_SEND;
            idx_d      = '0;
            tx_crc_d   = '0;
            tx_data_d  = STAT_HDR;
            tx_valid_d = 1'b1;
            tx_busy_d  = 1'b1;
         end
         TX_SEND: begin
            if (tx_valid_q && tx_ready) begin
               if (idx_q == 4'd11) begin
                  tx_state_d = TX_IDLE;
                  tx_data_d  = '0;
                  tx_valid_d = 1'b0;
                  tx_busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 4'd1;
                  // CRC folds in bytes 1..10 as each is handed off; the
                  // byte following byte 10 is therefore the finished CRC.
                  if (idx_q != 4'd0) begin
                     tx_crc_d = crc8_step(tx_crc_q, tx_data_q);
                  end
                  if (idx_q == 4'd0) begin
                     tx_data_d = BOARD_ID;
                  end else if (idx_q == 4'd10) begin
                     tx_data_d = crc8_step(tx_crc_q, tx_data_q);
                  end else begin
                     tx_data_d = buf_q[71:64];
                     buf_d     = {buf_q[63:0], 8'h00};
                  end
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_data           = tx_data_q;
   assign tx_valid          = tx_valid_q;
   assign tx_busy           = tx_busy_q;
   assign setpoint          = setpoint_q;
   assign control_mode      = ctrl_mode_q;
   assign cmd_strobe        = strobe_q;
   assign frame_error_count = err_q;

endmodule

// File: doc/motor_link_responder.md
# motor_link_responder

Board-side end of the motor UART link. Parses command frames arriving from the FPGA-side host controller, validates them with CRC-8, and latches setpoint and control mode for the local motor controller. For each valid command addressed to this board, it returns a status frame carrying encoder and displacement data. It sits between the board's byte-level UART receiver/transmitter and the local PID loop.

## Interface
- BOARD_ID, 8'h00, this board's address; frames carrying any other ID are ignored
- CLOCK_FREQ_HZ, 50_000_000, clk frequency
- TIMEOUT_US, 100, maximum allowed inter-byte gap inside a frame
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte, valid only while rx_valid is high
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
- encoder0_position  in  24  signed; sampled at response start
- encoder1_position  in  24  signed; sampled at response start
- displacement  in  24  signed; sampled at response start
- setpoint  out  24  signed; last valid commanded setpoint
- control_mode  out  8  last valid commanded mode
- cmd_strobe  out  1  one-cycle pulse on each setpoint/control_mode update
- frame_error_count  out  16  CRC failures plus timeouts; saturates at 16'hFFFF
- tx_busy  out  1  high while a status frame is in flight

## Operation
- Command frame, 7 bytes: 8'hAA, id, mode, sp[23:16], sp[15:8], sp[7:0], crc.
- Status frame, 12 bytes: 8'h55, BOARD_ID, enc0[23:16..7:0], enc1[23:16..7:0], disp[23:16..7:0], crc. All multi-byte fields are sent MSB first.
- CRC-8 definition:
  - polynomial 0x07, initial value 0x00, MSB-first, no reflection, no final XOR
  - coverage: every byte after the header, up to but excluding the crc byte
- RX state machine: HUNT → ID → MODE → SP2 → SP1 → SP0 → CRC → HUNT.
  - HUNT discards all bytes except 8'hAA.
  - 8'hAA received mid-frame is treated as data; there is no resync.
- On the CRC byte, two cases:
  - Computed CRC mismatches: increment frame_error_count; no output change.
  - CRC matches and id == BOARD_ID: update setpoint and control_mode, pulse cmd_strobe, request a response.
- id mismatch with good CRC: frame silently dropped; no counter change, no response.
- Timeout:
  - limit: TIMEOUT_US*CLOCK_FREQ_HZ/1_000_000 cycles with no rx_valid while in any state other than HUNT
  - action: return to HUNT and increment frame_error_count
  - the gap counter clears on every rx_valid
- TX state machine: IDLE → SEND (bytes 0..11) → IDLE.
  - On a response request in IDLE, snapshot encoder0_position, encoder1_position and displacement into a 72-bit buffer, then run the CRC over bytes 1..10.
  - The CRC is computed incrementally as bytes are handed off.
- A response request while TX is not IDLE is dropped. The in-flight frame is unaffected, and outputs still update.
- The RX parser runs independently of TX and keeps accepting bytes during transmission.
- Reset values, and state forced by reset mid-operation:
  - setpoint 0, control_mode 0, cmd_strobe 0
  - tx_data 0, tx_valid 0, tx_busy 0
  - frame_error_count 0
  - both state machines in HUNT/IDLE, CRC registers 0

## Timing
- rx_valid is sampled on the rising edge; every byte is consumed in one cycle, with no backpressure on RX.
- setpoint, control_mode and cmd_strobe update on the edge after the CRC byte's rx_valid cycle; this is one-cycle latency.
- Status snapshot happens on the same edge as the cmd_strobe assertion. tx_valid rises on the following edge with tx_data = 8'h55.
- Byte handoff:
  - tx_data and tx_valid stay stable until the tx_valid && tx_ready edge
  - the next byte is presented on the next edge
  - no idle cycles are inserted when tx_ready is held high, so a frame takes 12 cycles minimum
- tx_busy is high from the cycle tx_valid first rises through the cycle the crc byte is accepted.
- On a timeout, the count increments on the edge at which the gap counter reaches the limit.

## Test plan
- Reset, then frame AA 00 00 00 00 00 00 with BOARD_ID=0 → setpoint=0, cmd_strobe pulses once; status frame 55 00 + 9 data bytes + model CRC; frame_error_count=0.
- Frame AA 00 01 FF FF 9C crc(model), with encoders 24'h123456 / 24'hFEDCBA and displacement -5 → setpoint=-100, control_mode=1; status bytes 12 34 56 FE DC BA FF FF FB, then correct CRC.
- Same frame with crc byte XOR 8'h01 → no strobe, outputs unchanged, frame_error_count=1, no TX.
- Valid frame with id=8'h03 while BOARD_ID=0 → no update, no TX, count unchanged; a following valid id-0 frame is accepted normally.
- Stop after 3 bytes, idle for timeout+1 cycles, then send a full valid frame → count=1, second frame accepted.
- Hold tx_ready low for 20 cycles mid-response while a second valid frame arrives → tx_data stable throughout; second setpoint applied; only one 12-byte frame emitted; reset asserted mid-frame returns tx_valid to 0 immediately.
